// File: rtl/d_pipe_reg_pkg.sv
// rtl/d_pipe_reg_pkg.sv - shared Y86 icode/stat constants and decode-register field image
package d_pipe_reg_pkg;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_POPQ   = 4'd11;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [3:0]  NOP_ICODE = I_NOP;
    localparam logic [3:0]  NOP_IFUN  = 4'h0;
    localparam logic [3:0]  NOP_RA    = REG_NONE;
    localparam logic [3:0]  NOP_RB    = REG_NONE;
    localparam logic [63:0] NOP_VALC  = 64'h0;
    localparam logic [63:0] NOP_VALP  = 64'h0;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } d_fields_t;

    // The stat of an injected bubble is a module parameter, so it is passed in.
    function automatic d_fields_t nop_image(input logic [2:0] stat);
        d_fields_t f;
        f.stat  = stat;
        f.icode = NOP_ICODE;
        f.ifun  = NOP_IFUN;
        f.rA    = NOP_RA;
        f.rB    = NOP_RB;
        f.valC  = NOP_VALC;
        f.valP  = NOP_VALP;
        return f;
    endfunction

endpackage

// File: rtl/d_pipe_reg_sat_counter.sv
// rtl/d_pipe_reg_sat_counter.sv - saturating event counter with asynchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/d_pipe_reg.sv
// rtl/d_pipe_reg.sv - decode-stage pipeline register with stall/bubble control and event counters
module d_pipe_reg
    import d_pipe_reg_pkg::*;
#(
    parameter int         CNT_W = 32,
    parameter logic [2:0] AOK   = 3'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             bubble,
    input  logic [2:0]       f_stat,
    input  logic [3:0]       f_icode,
    input  logic [3:0]       f_ifun,
    input  logic [3:0]       f_rA,
    input  logic [3:0]       f_rB,
    input  logic [63:0]      f_valC,
    input  logic [63:0]      f_valP,
    output logic [2:0]       D_stat,
    output logic [3:0]       D_icode,
    output logic [3:0]       D_ifun,
    output logic [3:0]       D_rA,
    output logic [3:0]       D_rB,
    output logic [63:0]      D_valC,
    output logic [63:0]      D_valP,
    output logic             D_is_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    d_fields_t r_d;
    d_fields_t w_f;
    logic      r_is_bubble;
    logic      w_stall_inc;

    assign w_f = '{stat: f_stat, icode: f_icode, ifun: f_ifun, rA: f_rA,
                   rB: f_rB, valC: f_valC, valP: f_valP};

    // Contents are never interpreted: halt/error codes pass straight through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d         <= nop_image(AOK);
            r_is_bubble <= 1'b1;
        end else if (bubble) begin
            r_d         <= nop_image(AOK);
            r_is_bubble <= 1'b1;
        end else if (!stall) begin
            r_d         <= w_f;
            r_is_bubble <= 1'b0;
        end
    end

    assign D_stat      = r_d.stat;
    assign D_icode     = r_d.icode;
    assign D_ifun      = r_d.ifun;
    assign D_rA        = r_d.rA;
    assign D_rB        = r_d.rB;
    assign D_valC      = r_d.valC;
    assign D_valP      = r_d.valP;
    assign D_is_bubble = r_is_bubble;

    // A bubble takes precedence, so a coincident stall is not counted.
    assign w_stall_inc = stall & ~bubble;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (bubble),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_d_pipe_reg.sv
// tb/tb_d_pipe_reg.sv - self-checking bench for d_pipe_reg (table, corner sequences, random vs model)
module tb_d_pipe_reg;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } fld_t;

    typedef struct {
        logic        stall;
        logic        bubble;
        fld_t        f;
        fld_t        exp_d;
        logic        exp_isb;
        int unsigned exp_sc;
        int unsigned exp_bc;
    } vec_t;

    localparam fld_t NOP = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF,
                             valC: 64'h0, valP: 64'h0};

    logic clk = 1'b0;
    logic reset, stall, bubble;
    fld_t fin;

    fld_t        d_main, d_sat;
    logic        isb_main, isb_sat;
    logic [31:0] sc_main, bc_main;
    logic [2:0]  sc_sat, bc_sat;

    int total = 0;
    int bad   = 0;

    fld_t    m_d;
    logic    m_isb;
    longint  m_sc, m_bc;

    always #5 clk = ~clk;

    d_pipe_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
        .f_stat(fin.stat), .f_icode(fin.icode), .f_ifun(fin.ifun), .f_rA(fin.rA),
        .f_rB(fin.rB), .f_valC(fin.valC), .f_valP(fin.valP),
        .D_stat(d_main.stat), .D_icode(d_main.icode), .D_ifun(d_main.ifun),
        .D_rA(d_main.rA), .D_rB(d_main.rB), .D_valC(d_main.valC), .D_valP(d_main.valP),
        .D_is_bubble(isb_main), .stall_cnt(sc_main), .bubble_cnt(bc_main)
    );

    d_pipe_reg #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
        .f_stat(fin.stat), .f_icode(fin.icode), .f_ifun(fin.ifun), .f_rA(fin.rA),
        .f_rB(fin.rB), .f_valC(fin.valC), .f_valP(fin.valP),
        .D_stat(d_sat.stat), .D_icode(d_sat.icode), .D_ifun(d_sat.ifun),
        .D_rA(d_sat.rA), .D_rB(d_sat.rB), .D_valC(d_sat.valC), .D_valP(d_sat.valP),
        .D_is_bubble(isb_sat), .stall_cnt(sc_sat), .bubble_cnt(bc_sat)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: one clock edge of the decode register, by the stated priority rules.
    task automatic model_edge();
        if (bubble) begin
            m_d = NOP; m_isb = 1'b1; m_bc++;
        end else if (stall) begin
            m_sc++;
        end else begin
            m_d = fin; m_isb = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_d = NOP; m_isb = 1'b1; m_sc = 0; m_bc = 0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_d"},      160'(d_main),  160'(m_d));
        chk({tag, "_isb"},    160'(isb_main), 160'(m_isb));
        chk({tag, "_sc"},     160'(sc_main), 160'(m_sc));
        chk({tag, "_bc"},     160'(bc_main), 160'(m_bc));
        chk({tag, "_sat_d"},  160'(d_sat),   160'(m_d));
        chk({tag, "_sat_sc"}, 160'(sc_sat),  160'((m_sc > 7) ? 7 : m_sc));
        chk({tag, "_sat_bc"}, 160'(bc_sat),  160'((m_bc > 7) ? 7 : m_bc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic async_reset_pulse(input string tag);
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk_model(tag);
        #1 reset = 1'b0;
    endtask

    function automatic fld_t rand_f();
        fld_t f;
        f.stat  = 3'($urandom_range(0, 7));
        f.icode = 4'($urandom);
        f.ifun  = 4'($urandom);
        f.rA    = 4'($urandom);
        f.rB    = 4'($urandom);
        f.valC  = {$urandom, $urandom};
        f.valP  = {$urandom, $urandom};
        return f;
    endfunction

    fld_t IRM, JNK1, JNK2, MRM, NXT, HLT, JNK3;
    vec_t vt[10];

    initial begin
        IRM  = '{stat: 3'd1, icode: 4'h3, ifun: 4'h0, rA: 4'hF, rB: 4'h2, valC: 64'h100, valP: 64'h10A};
        JNK1 = '{stat: 3'd1, icode: 4'h6, ifun: 4'h1, rA: 4'h1, rB: 4'h2, valC: 64'h999, valP: 64'h888};
        JNK2 = '{stat: 3'd4, icode: 4'h2, ifun: 4'h3, rA: 4'h4, rB: 4'h5, valC: 64'h777, valP: 64'h666};
        MRM  = '{stat: 3'd1, icode: 4'h5, ifun: 4'h0, rA: 4'h3, rB: 4'h4, valC: 64'h20,  valP: 64'h114};
        NXT  = '{stat: 3'd1, icode: 4'hA, ifun: 4'h0, rA: 4'h1, rB: 4'hF, valC: 64'h0,   valP: 64'h200};
        HLT  = '{stat: 3'd2, icode: 4'h0, ifun: 4'h0, rA: 4'hF, rB: 4'hF, valC: 64'h0,   valP: 64'h300};
        JNK3 = '{stat: 3'd3, icode: 4'h8, ifun: 4'h0, rA: 4'h0, rB: 4'h0, valC: 64'h5,   valP: 64'h6};

        vt[0] = '{1'b0, 1'b0, IRM,  IRM, 1'b0, 0, 0};
        vt[1] = '{1'b1, 1'b0, JNK1, IRM, 1'b0, 1, 0};
        vt[2] = '{1'b1, 1'b0, JNK2, IRM, 1'b0, 2, 0};
        vt[3] = '{1'b1, 1'b0, JNK3, IRM, 1'b0, 3, 0};
        vt[4] = '{1'b0, 1'b0, MRM,  MRM, 1'b0, 3, 0};
        vt[5] = '{1'b0, 1'b1, JNK1, NOP, 1'b1, 3, 1};
        vt[6] = '{1'b0, 1'b0, NXT,  NXT, 1'b0, 3, 1};
        vt[7] = '{1'b1, 1'b1, JNK2, NOP, 1'b1, 3, 2};
        vt[8] = '{1'b0, 1'b0, HLT,  HLT, 1'b0, 3, 2};
        vt[9] = '{1'b1, 1'b0, JNK3, HLT, 1'b0, 4, 2};

        reset = 1'b1; stall = 1'b0; bubble = 1'b0; fin = JNK1;
        #1;
        model_reset();
        chk_model("por");
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven: load, 3-edge stall, bubble after mrmovq, stall+bubble, halt passthrough.
        for (int i = 0; i < 10; i++) begin
            stall = vt[i].stall; bubble = vt[i].bubble; fin = vt[i].f;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_d", i),   160'(d_main),   160'(vt[i].exp_d));
            chk($sformatf("vec%0d_isb", i), 160'(isb_main), 160'(vt[i].exp_isb));
            chk($sformatf("vec%0d_sc", i),  160'(sc_main),  160'(vt[i].exp_sc));
            chk($sformatf("vec%0d_bc", i),  160'(bc_main),  160'(vt[i].exp_bc));
        end

        // Reset asserted between edges takes effect without a clock.
        stall = 1'b1; bubble = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_d",   160'(d_main),   160'(NOP));
        chk("rst_mid_isb", 160'(isb_main), 160'(1'b1));
        chk("rst_mid_sc",  160'(sc_main),  160'(0));
        chk("rst_mid_bc",  160'(bc_main),  160'(0));
        @(posedge clk);
        #1;
        chk("rst_hold_d", 160'(d_main), 160'(NOP));
        reset = 1'b0;

        // Saturation with CNT_W=3.
        stall = 1'b1; bubble = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            fin = rand_f();
            @(posedge clk);
            #1;
            chk($sformatf("sat_sc%0d", i), 160'(sc_sat), 160'((i > 7) ? 7 : i));
        end
        chk("sat_main_sc", 160'(sc_main), 160'(10));
        chk("sat_hold_d",  160'(d_main),  160'(NOP));

        // Mid-stall reset while holding a ret.
        stall = 1'b0;
        fin = '{stat: 3'd1, icode: 4'h9, ifun: 4'h0, rA: 4'h4, rB: 4'hF, valC: 64'h0, valP: 64'h401};
        @(posedge clk); #1;
        chk("ret_load", 160'(d_main.icode), 160'(4'h9));
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fin = rand_f();
            @(posedge clk); #1;
            chk($sformatf("ret_hold%0d", i), 160'(d_main.icode), 160'(4'h9));
        end
        #2 reset = 1'b1;
        #1;
        chk("mrst_d",   160'(d_main),   160'(NOP));
        chk("mrst_isb", 160'(isb_main), 160'(1'b1));
        chk("mrst_sc",  160'(sc_main),  160'(0));
        chk("mrst_bc",  160'(bc_main),  160'(0));
        #1 reset = 1'b0;
        stall = 1'b0;
        fin = NXT;
        @(posedge clk); #1;
        chk("mrst_first_d",   160'(d_main),   160'(NXT));
        chk("mrst_first_isb", 160'(isb_main), 160'(1'b0));

        // Randomised run against the reference model.
        m_d = NXT; m_isb = 1'b0; m_sc = 0; m_bc = 0;
        for (int i = 0; i < 400; i++) begin
            stall  = ($urandom_range(0, 99) < 35);
            bubble = ($urandom_range(0, 99) < 20);
            fin    = rand_f();
            step();
            chk_model($sformatf("rnd%0d", i));
            if ($urandom_range(0, 99) < 3) async_reset_pulse($sformatf("rrst%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
